ccp_rdrsp_out_ctrl: RTL
=======================

# ccp_rdrsp_out_ctrl

Read-response output stage of the CCP that produces the `cache_rdrsp_*` channel consumed by the controller. It accepts per-transaction command descriptors from the p2 stage and sequences data beats from one of two sources:
- the data-array read path, which carries read-only and write-through line data;
- the write-port bypass path.

It generates beat count, last, byte enables and cancel, and holds the channel stable under backpressure.

## Interface
Parameters
- DATA_W, 128, data beat width
- BYTE_EN_W, DATA_W/8, byte-enable width
- BURST_LEN_W, 2, burst length field width (beats = burst_len+1)
- CMD_DEPTH, 4, command FIFO depth (power of 2)

Ports (one clock; reset is asynchronous and active-low)
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- cmd_valid  in  1  command descriptor valid
- cmd_ready  out  1  command FIFO not full
- cmd_burst_len  in  BURST_LEN_W  beats minus one
- cmd_src  in  2  0=array read-only, 1=write-through (array path), 2=bypass, 3=reserved
- arr_valid  in  1  array beat valid
- arr_ready  out  1  array beat accepted
- arr_data  in  DATA_W  array beat data
- arr_err  in  1  uncorrectable error on this beat
- byp_valid  in  1  bypass beat valid
- byp_ready  out  1  bypass beat accepted
- byp_data  in  DATA_W  bypass data
- byp_byteen  in  BYTE_EN_W  bypass byte enables
- byp_last  in  1  bypass last beat
- cache_rdrsp_valid  out  1  response beat valid
- ctrl_rdrsp_ready  in  1  controller ready
- cache_rdrsp_data  out  DATA_W  response data
- cache_rdrsp_byteen  out  BYTE_EN_W  response byte enables
- cache_rdrsp_last  out  1  last beat of transaction
- cache_rdrsp_cancel  out  1  beat cancelled (uncorrectable error)
- proto_err  out  1  sticky protocol-error flag

## Operation
- Command FIFO, CMD_DEPTH entries of {burst_len, src}.
  - Push on cmd_valid & cmd_ready.
  - cmd_ready = !full; no push-through when full, even if a pop occurs in the same cycle.
- Output register holds one beat. load = head_valid & (!cache_rdrsp_valid | ctrl_rdrsp_ready) & selected source valid.
- Source selection by head src:
  - 0 or 1: arr. arr_ready = load; cache_rdrsp_byteen = all ones; data = arr_data.
  - 2: byp. byp_ready = load; byteen = byp_byteen; data = byp_data.
  - The unselected source's ready is 0.
- beat_cnt (BURST_LEN_W bits):
  - Increments on each load.
  - Clears on load of the last beat (beat_cnt == burst_len).
  - cache_rdrsp_last = that comparison, registered with the beat.
- FIFO pop on load of the last beat. beat_cnt and pop are simultaneous.
- Cancel (src 0/1 only):
  - cancel_sticky sets on a loaded beat with arr_err.
  - cache_rdrsp_cancel = arr_err | cancel_sticky for that beat and all later beats of the same transaction.
  - Clears with the last-beat load.
  - Bypass beats never cancel.
- Bypass last check: on a bypass load, byp_last != computed last sets proto_err. Computed last always governs cache_rdrsp_last and the pop.
- src 3: head popped in one cycle with no beat produced and no source ready asserted; proto_err set.
- proto_err clears only on reset.
- While cache_rdrsp_valid & !ctrl_rdrsp_ready: valid, data, byteen, last and cancel are held unchanged.

## Timing
- Reset: cache_rdrsp_valid/last/cancel=0, data/byteen=0, proto_err=0, FIFO empty, beat_cnt=0, cancel_sticky=0, cmd_ready=1.
- Command pushed in cycle N is at the head in cycle N+1; the earliest load is N+1.
- Source beat accepted in cycle M gives cache_rdrsp_valid in cycle M+1.
- Back-to-back: one beat per cycle with continuous ready, including across a transaction boundary. The next command's first beat loads in the cycle after the previous last beat's load.
- Empty FIFO: arr_ready=byp_ready=0; a source valid presented with no command is not consumed.
- Reset mid-burst: the FIFO, the output register and beat_cnt are discarded immediately (async).

## Test plan
- Read-only burst: cmd {len=3, src=0}, 4 arr beats, ready=1 -> 4 rdrsp beats, byteen=all-ones, last only on beat 3, one pop.
- Backpressure: ready low for 3 cycles with valid up on beat 1 of {len=1, src=1} -> data, byteen, last and cancel identical across stall cycles; arr_ready=0 while stalled.
- Bypass: cmd {len=1, src=2}, byp beats with byteen 0x00FF then 0xFF00 and byp_last on beat 1 -> byteen passed through, last on beat 1, proto_err=0. Repeat with byp_last on beat 0 -> proto_err=1, last still on beat 1.
- Cancel: {len=3, src=0}, arr_err on beat 1 -> cancel = 0,1,1,1. Next transaction shows cancel=0.
- FIFO full: push 4 commands with no source data -> cmd_ready=0 on the 5th. Popping the head by completing its burst re-raises cmd_ready the next cycle.
- Reserved src=3 between two reads -> no beat emitted for it, proto_err=1, following read completes normally.

Source files
------------

// File: rtl/ccp_rdrsp_out_ctrl.sv
// ---------------------------------------------------------------------------
// ccp_rdrsp_out_ctrl
//
// Read-response output stage. Queues per-transaction command descriptors
// {burst_len, src} and, for the descriptor at the head, moves data beats from
// either the data-array read path (src 0/1) or the write-port bypass path
// (src 2) into a single output register that drives the cache_rdrsp channel.
// Generates last (from an internal beat counter), byte enables and cancel, and
// holds the output register stable while the controller applies backpressure.
//
// Ports
//   clk, reset_n                         clock, async active-low reset
//   cmd_valid/cmd_ready                  descriptor push handshake
//   cmd_burst_len, cmd_src               descriptor fields (beats-1, source)
//   arr_valid/arr_ready/arr_data/arr_err array read beat + uncorrectable error
//   byp_valid/byp_ready/byp_data/
//   byp_byteen/byp_last                  bypass beat
//   cache_rdrsp_valid/ctrl_rdrsp_ready   response handshake
//   cache_rdrsp_data/byteen/last/cancel  response beat
//   proto_err                            sticky protocol-error flag
// ---------------------------------------------------------------------------
module ccp_rdrsp_out_ctrl #(
    parameter int DATA_W      = 128,
    parameter int BYTE_EN_W   = DATA_W / 8,
    parameter int BURST_LEN_W = 2,
    parameter int CMD_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [BURST_LEN_W-1:0] cmd_burst_len,
    input  logic [1:0]             cmd_src,
    input  logic                   arr_valid,
    output logic                   arr_ready,
    input  logic [DATA_W-1:0]      arr_data,
    input  logic                   arr_err,
    input  logic                   byp_valid,
    output logic                   byp_ready,
    input  logic [DATA_W-1:0]      byp_data,
    input  logic [BYTE_EN_W-1:0]   byp_byteen,
    input  logic                   byp_last,
    output logic                   cache_rdrsp_valid,
    input  logic                   ctrl_rdrsp_ready,
    output logic [DATA_W-1:0]      cache_rdrsp_data,
    output logic [BYTE_EN_W-1:0]   cache_rdrsp_byteen,
    output logic                   cache_rdrsp_last,
    output logic                   cache_rdrsp_cancel,
    output logic                   proto_err
);

    localparam int              PTR_W    = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(CMD_DEPTH);

    // Descriptor storage: payload only, no reset needed.
    logic [BURST_LEN_W-1:0] len_mem [CMD_DEPTH];
    logic [1:0]             src_mem [CMD_DEPTH];

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         cnt_q, cnt_d;
    logic [BURST_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic                   sticky_q, sticky_d;
    logic                   proto_q, proto_d;
    logic                   vld_q, vld_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [BYTE_EN_W-1:0]   be_q, be_d;
    logic                   last_q, last_d;
    logic                   cancel_q, cancel_d;

    logic                   head_valid;
    logic [BURST_LEN_W-1:0] head_len;
    logic [1:0]             head_src;
    logic                   out_free;
    logic                   sel_arr, sel_byp, sel_rsv;
    logic                   load_arr, load_byp, load;
    logic                   is_last;
    logic                   push, pop;

    assign head_valid = (cnt_q != '0);
    assign head_len   = len_mem[rd_ptr_q];
    assign head_src   = src_mem[rd_ptr_q];

    // No push-through: a full FIFO refuses even if the head pops this cycle.
    assign cmd_ready  = (cnt_q != FULL_CNT);
    assign push       = cmd_valid & cmd_ready;

    assign out_free   = ~vld_q | ctrl_rdrsp_ready;
    assign sel_arr    = head_valid & ~head_src[1];
    assign sel_byp    = head_valid & (head_src == 2'd2);
    assign sel_rsv    = head_valid & (head_src == 2'd3);
    assign load_arr   = sel_arr & out_free & arr_valid;
    assign load_byp   = sel_byp & out_free & byp_valid;
    assign load       = load_arr | load_byp;
    assign is_last    = (beat_cnt_q == head_len);

    // A reserved descriptor is discarded on its own, without producing a beat.
    assign pop        = (load & is_last) | sel_rsv;

    assign arr_ready  = load_arr;
    assign byp_ready  = load_byp;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        beat_cnt_d = beat_cnt_q;
        sticky_d   = sticky_q;
        proto_d    = proto_q;
        vld_d      = vld_q;
        data_d     = data_q;
        be_d       = be_q;
        last_d     = last_q;
        cancel_d   = cancel_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (load) begin
            beat_cnt_d = is_last ? '0 : beat_cnt_q + BURST_LEN_W'(1);
            vld_d      = 1'b1;
            data_d     = load_arr ? arr_data : byp_data;
            be_d       = load_arr ? '1 : byp_byteen;
            last_d     = is_last;
            // Once a beat of an array transaction is cancelled, every later
            // beat of that transaction is cancelled too.
            cancel_d   = load_arr & (arr_err | sticky_q);
        end else if (ctrl_rdrsp_ready) begin
            vld_d      = 1'b0;
        end

        if (load_arr) begin
            sticky_d = is_last ? 1'b0 : (sticky_q | arr_err);
        end

        // The internal count governs last; a disagreeing byp_last is only flagged.
        if ((load_byp & (byp_last != is_last)) | sel_rsv) begin
            proto_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            len_mem[wr_ptr_q] <= cmd_burst_len;
            src_mem[wr_ptr_q] <= cmd_src;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            beat_cnt_q <= '0;
            sticky_q   <= 1'b0;
            proto_q    <= 1'b0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            be_q       <= '0;
            last_q     <= 1'b0;
            cancel_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            beat_cnt_q <= beat_cnt_d;
            sticky_q   <= sticky_d;
            proto_q    <= proto_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            be_q       <= be_d;
            last_q     <= last_d;
            cancel_q   <= cancel_d;
        end
    end

    assign cache_rdrsp_valid  = vld_q;
    assign cache_rdrsp_data   = data_q;
    assign cache_rdrsp_byteen = be_q;
    assign cache_rdrsp_last   = last_q;
    assign cache_rdrsp_cancel = cancel_q;
    assign proto_err          = proto_q;

endmodule
